fadd_multicycle: RTL



---
 rtl/fadd_pkg.sv | 14 +
 rtl/fadd_multicycle_if.sv | 29 ++
 rtl/fadd_multicycle_chunk.sv | 31 +++
 rtl/fadd_multicycle.sv | 117 +++++++++++
 4 files changed

// File: rtl/fadd_pkg.sv
// Shared types and defaults for the multi-cycle chunked adder.
package fadd_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} fadd_state_e;

    localparam int unsigned FADD_WIDTH = 32;
    localparam int unsigned FADD_CHUNK = 8;

    // Width of the chunk index counter; never narrower than one bit.
    function automatic int unsigned idx_bits(input int unsigned nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/fadd_multicycle_if.sv
// Operand/result handshake bundle for fadd_multicycle.
interface fadd_multicycle_if
    import fadd_pkg::*;
#(
    parameter int unsigned WIDTH = FADD_WIDTH
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             overflow;

    modport master (
        output in_valid, a, b, c_in, out_ready,
        input  in_ready, out_valid, sum, c_out, overflow
    );

    modport slave (
        input  in_valid, a, b, c_in, out_ready,
        output in_ready, out_valid, sum, c_out, overflow
    );

endinterface

// File: rtl/fadd_multicycle_chunk.sv
// Combinational ripple of full-adder cells over one CHUNK-bit slice.
module fadd_chunk
    import fadd_pkg::*;
#(
    parameter int unsigned CHUNK = FADD_CHUNK
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             c_in,
    output logic [CHUNK-1:0] sum,
    output logic             c_out,
    output logic             c_msb
);

    logic [CHUNK:0] carry;

    // Ripple the carry through CHUNK full-adder cells.
    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = c_in;
        for (int unsigned i = 0; i < CHUNK; i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    end

    assign c_out = carry[CHUNK];
    assign c_msb = carry[CHUNK - 1];

endmodule

// File: rtl/fadd_multicycle.sv
// Multi-cycle adder: one CHUNK-bit slice per clock through a registered carry,
// behind valid/ready handshakes on both sides.
module fadd_multicycle
    import fadd_pkg::*;
#(
    parameter int unsigned WIDTH = FADD_WIDTH,
    parameter int unsigned CHUNK = FADD_CHUNK
) (
    input  logic               clk,
    input  logic               rst_n,
    fadd_multicycle_if.slave   bus
);

    localparam int unsigned      NCHUNK = WIDTH / CHUNK;
    localparam int unsigned      IDXW   = idx_bits(NCHUNK);
    localparam logic [IDXW-1:0]  LAST   = IDXW'(NCHUNK - 1);

    if ((CHUNK == 0) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_param_check
        $error("fadd_multicycle: WIDTH must be a positive multiple of CHUNK");
    end

    fadd_state_e      state_q, state_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             c_out_q, c_out_d;
    logic             ovf_q, ovf_d;

    logic [CHUNK-1:0] op_a, op_b, ch_sum;
    logic             ch_cout, ch_cmsb;

    assign op_a = a_q[idx_q * CHUNK +: CHUNK];
    assign op_b = b_q[idx_q * CHUNK +: CHUNK];

    fadd_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a     (op_a),
        .b     (op_b),
        .c_in  (carry_q),
        .sum   (ch_sum),
        .c_out (ch_cout),
        .c_msb (ch_cmsb)
    );

    // Handshake outputs depend on state (and reset) only.
    assign bus.in_ready  = rst_n && (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.sum       = sum_q;
    assign bus.c_out     = c_out_q;
    assign bus.overflow  = ovf_q;

    // Next-state logic: accept operands, step one chunk per cycle, hold result.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    carry_d = bus.c_in;
                    idx_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                sum_d[idx_q * CHUNK +: CHUNK] = ch_sum;
                carry_d = ch_cout;
                if (idx_q == LAST) begin
                    c_out_d = ch_cout;
                    ovf_d   = ch_cout ^ ch_cmsb;
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule
